// File: rtl/floo_vc_input_buffer.sv
// Per-virtual-channel input FIFO bank fed by one shared physical flit bus.
// Each VC owns an independent FIFO, so a stalled VC never blocks the others.
module floo_vc_input_buffer #(
    parameter int unsigned NumVirtChannels = 2,
    parameter int unsigned Depth           = 2,
    parameter type         flit_t          = logic,
    parameter int unsigned CntWidth        = $clog2(Depth + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic  [NumVirtChannels-1:0]              valid_i,
    output logic  [NumVirtChannels-1:0]              ready_o,
    input  flit_t                                    data_i,
    output logic  [NumVirtChannels-1:0]              valid_o,
    input  logic  [NumVirtChannels-1:0]              ready_i,
    output flit_t [NumVirtChannels-1:0]              data_o,
    output logic  [NumVirtChannels-1:0][CntWidth-1:0] usage_o,
    output logic                                     error_o
);

    localparam int unsigned         PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] FullCnt  = CntWidth'(Depth);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and ready here depends only on
    // registered fill state, never on valid_i or ready_i.
    logic [NumVirtChannels-1:0] w_push;
    logic [NumVirtChannels-1:0] w_pop;
    logic                       w_found;
    logic                       w_multi;
    logic                       r_error;

    // Only the lowest-index VC that can accept is written when valid_i is multi-hot.
    always_comb begin
        w_push  = '0;
        w_found = 1'b0;
        for (int v = 0; v < NumVirtChannels; v++) begin
            if (!w_found && valid_i[v] && ready_o[v]) begin
                w_push[v] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    assign w_pop   = valid_o & ready_i;
    assign w_multi = (valid_i & (valid_i - 1'b1)) != '0;

    for (genvar v = 0; v < NumVirtChannels; v++) begin : g_vc
        logic [PtrWidth-1:0] r_wptr;
        logic [PtrWidth-1:0] r_rptr;
        logic [CntWidth-1:0] r_usage;
        flit_t               r_mem [Depth];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_usage <= '0;
            end else begin
                if (w_push[v]) begin
                    r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
                end
                if (w_pop[v]) begin
                    r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
                end
                r_usage <= r_usage + CntWidth'(w_push[v]) - CntWidth'(w_pop[v]);
            end
        end

        // Storage needs no reset: the flushed pointers and count hide stale entries.
        always_ff @(posedge clk_i) begin
            if (w_push[v]) begin
                r_mem[r_wptr] <= data_i;
            end
        end

        assign ready_o[v] = (r_usage != FullCnt);
        assign valid_o[v] = (r_usage != '0);
        assign data_o[v]  = r_mem[r_rptr];
        assign usage_o[v] = r_usage;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_error <= 1'b0;
        end else if (w_multi) begin
            r_error <= 1'b1;
        end
    end

    assign error_o = r_error;

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!w_multi)
            else $warning("floo_vc_input_buffer: multi-hot valid_i, extra flits dropped");
        end
    end

endmodule

// File: tb/tb_floo_vc_input_buffer.sv
// Directed bench for floo_vc_input_buffer: a Depth=2 instance for the main
// scenarios and a Depth=3 instance for the wrap-around stream.
module tb_floo_vc_input_buffer;

    logic clk;
    logic rst_n;

    logic [1:0]      valid_i, ready_o, valid_o, ready_i;
    logic [7:0]      data_i;
    logic [1:0][7:0] data_o;
    logic [1:0][1:0] usage_o;
    logic            error_o;

    logic [1:0]      b_valid_i, b_ready_o, b_valid_o, b_ready_i;
    logic [7:0]      b_data_i;
    logic [1:0][7:0] b_data_o;
    logic [1:0][1:0] b_usage_o;
    logic            b_error_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    floo_vc_input_buffer #(
        .NumVirtChannels(2), .Depth(2), .flit_t(logic [7:0])
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .usage_o(usage_o), .error_o(error_o)
    );

    floo_vc_input_buffer #(
        .NumVirtChannels(2), .Depth(3), .flit_t(logic [7:0])
    ) u_dut_d3 (
        .clk_i(clk), .rst_ni(rst_n),
        .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
        .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o),
        .usage_o(b_usage_o), .error_o(b_error_o)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vc(input int vc, input logic [7:0] d);
        valid_i = 2'b00;
        valid_i[vc] = 1'b1;
        data_i = d;
        tick();
        valid_i = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_i = '0; ready_i = '0; data_i = '0;
        b_valid_i = '0; b_ready_i = '0; b_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_i = 2'b11;
        for (int i = 0; i < 10; i++) begin
            checks++; if (usage_o !== 4'h0) begin errors++; $display("FAIL reset_usage: got %h expected 0", usage_o); end
            checks++; if (valid_o !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", valid_o); end
            checks++; if (ready_o !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b expected 11", ready_o); end
            checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error_o); end
            tick();
        end
        ready_i = 2'b00;
    endtask

    task automatic test_fill();
        push_vc(0, 8'hA1);
        push_vc(0, 8'hA2);
        checks++; if (ready_o[0] !== 1'b0) begin errors++; $display("FAIL fill_ready0: got %b expected 0", ready_o[0]); end
        checks++; if (usage_o[0] !== 2'd2) begin errors++; $display("FAIL fill_usage0: got %0d expected 2", usage_o[0]); end
        checks++; if (ready_o[1] !== 1'b1) begin errors++; $display("FAIL fill_ready1: got %b expected 1", ready_o[1]); end
        checks++; if (data_o[0] !== 8'hA1) begin errors++; $display("FAIL fill_head0: got %h expected a1", data_o[0]); end
        ready_i = 2'b01;
        tick();
        checks++; if (data_o[0] !== 8'hA2) begin errors++; $display("FAIL fill_pop2: got %h expected a2", data_o[0]); end
        checks++; if (usage_o[0] !== 2'd1) begin errors++; $display("FAIL fill_usage_mid: got %0d expected 1", usage_o[0]); end
        tick();
        ready_i = 2'b00;
        checks++; if (usage_o[0] !== 2'd0) begin errors++; $display("FAIL fill_drained: got %0d expected 0", usage_o[0]); end
        checks++; if (valid_o[0] !== 1'b0) begin errors++; $display("FAIL fill_valid_end: got %b expected 0", valid_o[0]); end
    endtask

    task automatic test_hol();
        push_vc(0, 8'h11);
        push_vc(0, 8'h12);
        valid_i = 2'b10; data_i = 8'hB1; ready_i = 2'b10;
        checks++; if (valid_o[1] !== 1'b0) begin errors++; $display("FAIL hol_no_fallthrough: got %b expected 0", valid_o[1]); end
        tick();
        valid_i = 2'b00;
        checks++; if (valid_o[1] !== 1'b1) begin errors++; $display("FAIL hol_valid1: got %b expected 1", valid_o[1]); end
        checks++; if (data_o[1] !== 8'hB1) begin errors++; $display("FAIL hol_data1: got %h expected b1", data_o[1]); end
        checks++; if (usage_o[0] !== 2'd2) begin errors++; $display("FAIL hol_vc0_full: got %0d expected 2", usage_o[0]); end
        tick();
        checks++; if (valid_o[1] !== 1'b0) begin errors++; $display("FAIL hol_vc1_popped: got %b expected 0", valid_o[1]); end
        checks++; if (data_o[0] !== 8'h11) begin errors++; $display("FAIL hol_vc0_head: got %h expected 11", data_o[0]); end
        ready_i = 2'b01;
        tick();
        tick();
        ready_i = 2'b00;
        checks++; if (usage_o !== 4'h0) begin errors++; $display("FAIL hol_drained: got %h expected 0", usage_o); end
    endtask

    task automatic test_full_push_pop();
        push_vc(0, 8'hC1);
        push_vc(0, 8'hC2);
        valid_i = 2'b01; data_i = 8'hC3; ready_i = 2'b01;
        checks++; if (ready_o[0] !== 1'b0) begin errors++; $display("FAIL fpp_full_ready: got %b expected 0", ready_o[0]); end
        checks++; if (data_o[0] !== 8'hC1) begin errors++; $display("FAIL fpp_out1: got %h expected c1", data_o[0]); end
        tick();
        checks++; if (usage_o[0] !== 2'd1) begin errors++; $display("FAIL fpp_usage1: got %0d expected 1", usage_o[0]); end
        checks++; if (ready_o[0] !== 1'b1) begin errors++; $display("FAIL fpp_ready_rise: got %b expected 1", ready_o[0]); end
        checks++; if (data_o[0] !== 8'hC2) begin errors++; $display("FAIL fpp_out2: got %h expected c2", data_o[0]); end
        tick();
        valid_i = 2'b00;
        checks++; if (usage_o[0] !== 2'd1) begin errors++; $display("FAIL fpp_usage2: got %0d expected 1", usage_o[0]); end
        checks++; if (data_o[0] !== 8'hC3) begin errors++; $display("FAIL fpp_out3: got %h expected c3", data_o[0]); end
        tick();
        ready_i = 2'b00;
        checks++; if (usage_o[0] !== 2'd0) begin errors++; $display("FAIL fpp_drained: got %0d expected 0", usage_o[0]); end
    endtask

    task automatic test_wrap();
        int in_idx  = 0;
        int out_cnt = 0;
        int cyc     = 0;
        logic [7:0] exp_d;
        exp_q.delete();
        while ((in_idx < 10 || out_cnt < 10) && cyc < 300) begin
            b_valid_i = (in_idx < 10) ? 2'b10 : 2'b00;
            b_data_i  = 8'(in_idx);
            b_ready_i = (cyc < 5) ? 2'b00 : {($urandom_range(0, 2) != 0), 1'b0};
            checks++; if (b_usage_o[1] > 2'd3) begin errors++; $display("FAIL wrap_usage: got %0d expected <=3", b_usage_o[1]); end
            if (b_valid_o[1] && b_ready_i[1]) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                checks++; if (b_data_o[1] !== exp_d) begin errors++; $display("FAIL wrap_data: got %h expected %h", b_data_o[1], exp_d); end
                checks++; if (b_data_o[1] !== 8'(out_cnt)) begin errors++; $display("FAIL wrap_order: got %h expected %h", b_data_o[1], 8'(out_cnt)); end
                out_cnt++;
            end
            if (b_valid_i[1] && b_ready_o[1]) begin
                exp_q.push_back(8'(in_idx));
                in_idx++;
            end
            if (cyc == 5) begin
                checks++; if (b_usage_o[1] !== 2'd3) begin errors++; $display("FAIL wrap_fill3: got %0d expected 3", b_usage_o[1]); end
            end
            tick();
            cyc++;
        end
        b_valid_i = '0; b_ready_i = '0;
        checks++; if (out_cnt != 10) begin errors++; $display("FAIL wrap_count: got %0d expected 10", out_cnt); end
        checks++; if (b_valid_o[1] !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b expected 0", b_valid_o[1]); end
        checks++; if (b_error_o !== 1'b0) begin errors++; $display("FAIL wrap_error: got %b expected 0", b_error_o); end
    endtask

    task automatic test_violation_reset();
        valid_i = 2'b11; data_i = 8'hD0; ready_i = 2'b00;
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL viol_pre_error: got %b expected 0", error_o); end
        tick();
        valid_i = 2'b00;
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL viol_error: got %b expected 1", error_o); end
        checks++; if (usage_o[0] !== 2'd1) begin errors++; $display("FAIL viol_usage0: got %0d expected 1", usage_o[0]); end
        checks++; if (data_o[0] !== 8'hD0) begin errors++; $display("FAIL viol_data0: got %h expected d0", data_o[0]); end
        checks++; if (usage_o[1] !== 2'd0) begin errors++; $display("FAIL viol_usage1: got %0d expected 0", usage_o[1]); end
        ready_i = 2'b01;
        repeat (3) tick();
        ready_i = 2'b00;
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL viol_sticky: got %b expected 1", error_o); end
        push_vc(1, 8'h55);
        push_vc(0, 8'h66);
        checks++; if (usage_o !== {2'd1, 2'd1}) begin errors++; $display("FAIL rst_pre_usage: got %h expected 5", usage_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL rst_async_error: got %b expected 0", error_o); end
        checks++; if (usage_o !== 4'h0) begin errors++; $display("FAIL rst_async_usage: got %h expected 0", usage_o); end
        checks++; if (valid_o !== 2'b00) begin errors++; $display("FAIL rst_async_valid: got %b expected 00", valid_o); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (valid_o !== 2'b00) begin errors++; $display("FAIL rst_flushed: got %b expected 00", valid_o); end
        checks++; if (ready_o !== 2'b11) begin errors++; $display("FAIL rst_ready: got %b expected 11", ready_o); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hol();
        test_full_push_pop();
        test_wrap();
        test_violation_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
